sat_check_seq: RTL

- Multi-cycle, parametrised successor to the combinational clause-status checker in the DPLL datapath.
- Scans the clause database CHUNK clauses per cycle under a start/done handshake. Literal width per clause and an early-exit mode are configurable.
- Reports SAT (no live clauses) and UNSAT (a live clause with no remaining literals), the lowest conflicting clause index, and the live-clause count.
- Sits between the unit-propagation engine and the DPLL control FSM.

---
 rtl/sat_check_seq.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/sat_check_seq.sv
// Sequential clause-status checker: scans the clause database CHUNK clauses per
// cycle and reports SAT / UNSAT, the lowest conflicting clause and the live count.
module sat_check_seq #(
    parameter int MAX_CLAUSES = 1024,
    parameter int LITS        = 3,
    parameter int CHUNK       = 64,
    parameter int EARLY_EXIT  = 1,
    parameter int IDX_W       = $clog2(MAX_CLAUSES)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [MAX_CLAUSES*LITS-1:0]  clauses,
    input  logic [MAX_CLAUSES-1:0]       clause_active,
    input  logic [MAX_CLAUSES-1:0]       clause_valid,
    output logic                         busy,
    output logic                         done,
    output logic                         return_true,
    output logic                         return_false,
    output logic [IDX_W-1:0]             conflict_idx,
    output logic [IDX_W:0]               live_count
);

    localparam int NCHUNK = MAX_CLAUSES / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    function automatic logic [IDX_W:0] popcount(input logic [CHUNK-1:0] v);
        logic [IDX_W:0] n;
        n = {(IDX_W+1){1'b0}};
        for (int i = 0; i < CHUNK; i++) begin
            n = n + {{IDX_W{1'b0}}, v[i]};
        end
        return n;
    endfunction

    // Scanning downwards so the last hit is the lowest set position.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [CHUNK-1:0] v);
        logic [IDX_W-1:0] pos;
        pos = {IDX_W{1'b0}};
        for (int i = CHUNK - 1; i >= 0; i--) begin
            if (v[i]) begin
                pos = IDX_W'(i);
            end else begin
                pos = pos;
            end
        end
        return pos;
    endfunction

    state_t                         r_state;
    state_t                         w_state_n;
    logic   [CW-1:0]                r_chunk;
    logic                           r_any_live;
    logic                           r_conf;
    logic   [IDX_W-1:0]             r_idx;
    logic   [IDX_W:0]               r_cnt;
    logic                           r_busy;
    logic                           r_done;
    logic                           r_true;
    logic                           r_false;
    logic   [IDX_W-1:0]             r_conflict_idx;
    logic   [IDX_W:0]               r_live_count;

    logic   [NCHUNK-1:0][CHUNK-1:0] w_live_2d;
    logic   [NCHUNK-1:0][CHUNK-1:0] w_empty_2d;
    logic   [CHUNK-1:0]             w_live;
    logic   [CHUNK-1:0]             w_empty;
    logic   [IDX_W-1:0]             w_base;
    logic                           w_any_live_n;
    logic                           w_conf_n;
    logic   [IDX_W-1:0]             w_idx_n;
    logic   [IDX_W:0]               w_cnt_n;
    logic                           w_scan_end;

    for (genvar c = 0; c < NCHUNK; c++) begin : g_chunk
        for (genvar k = 0; k < CHUNK; k++) begin : g_clause
            localparam int J = c * CHUNK + k;
            assign w_live_2d[c][k]  = clause_valid[J] & clause_active[J];
            assign w_empty_2d[c][k] = clause_valid[J] & clause_active[J] & ~|clauses[J*LITS +: LITS];
        end
    end

    assign w_live  = w_live_2d[r_chunk];
    assign w_empty = w_empty_2d[r_chunk];
    assign w_base  = IDX_W'(r_chunk) * IDX_W'(CHUNK);

    // Accumulator update for the chunk currently selected by r_chunk.
    always_comb begin
        w_any_live_n = r_any_live | (|w_live);
        w_cnt_n      = r_cnt + popcount(w_live);
        w_conf_n     = r_conf;
        w_idx_n      = r_idx;
        if (!r_conf && (|w_empty)) begin
            w_conf_n = 1'b1;
            w_idx_n  = w_base + lowest_set(w_empty);
        end else begin
            w_conf_n = r_conf;
        end
        w_scan_end = (r_chunk == CW'(NCHUNK - 1)) || ((EARLY_EXIT != 0) && (|w_empty));
    end

    // Next-state logic.
    always_comb begin
        w_state_n = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_n = ST_SCAN;
                end else begin
                    w_state_n = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (w_scan_end) begin
                    w_state_n = ST_IDLE;
                end else begin
                    w_state_n = ST_SCAN;
                end
            end
            default: w_state_n = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    // Chunk counter, accumulators and registered results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chunk        <= {CW{1'b0}};
            r_any_live     <= 1'b0;
            r_conf         <= 1'b0;
            r_idx          <= {IDX_W{1'b0}};
            r_cnt          <= {(IDX_W+1){1'b0}};
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_true         <= 1'b0;
            r_false        <= 1'b0;
            r_conflict_idx <= {IDX_W{1'b0}};
            r_live_count   <= {(IDX_W+1){1'b0}};
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_chunk        <= {CW{1'b0}};
                        r_any_live     <= 1'b0;
                        r_conf         <= 1'b0;
                        r_idx          <= {IDX_W{1'b0}};
                        r_cnt          <= {(IDX_W+1){1'b0}};
                        r_busy         <= 1'b1;
                        r_true         <= 1'b0;
                        r_false        <= 1'b0;
                        r_conflict_idx <= {IDX_W{1'b0}};
                        r_live_count   <= {(IDX_W+1){1'b0}};
                    end
                end
                ST_SCAN: begin
                    r_chunk    <= r_chunk + {{(CW-1){1'b0}}, 1'b1};
                    r_any_live <= w_any_live_n;
                    r_conf     <= w_conf_n;
                    r_idx      <= w_idx_n;
                    r_cnt      <= w_cnt_n;
                    if (w_scan_end) begin
                        r_busy         <= 1'b0;
                        r_done         <= 1'b1;
                        r_true         <= ~w_any_live_n & ~w_conf_n;
                        r_false        <= w_conf_n;
                        r_conflict_idx <= w_idx_n;
                        r_live_count   <= w_cnt_n;
                    end
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign return_true  = r_true;
    assign return_false = r_false;
    assign conflict_idx = r_conflict_idx;
    assign live_count   = r_live_count;

endmodule
